// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the store buffer and its FIFO.
package arm_mem_pkg;

  localparam int unsigned DefDepth = 4;
  // Word-address compare width: cpu_adr[31:2].
  localparam int unsigned AdrW = 30;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StRdone
  } sb_state_e;

endpackage

// File: rtl/sbuf_fifo.sv
// Circular store-entry storage with pointers; every entry is exposed for address matching.
module sbuf_fifo
  import arm_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic                             pop,
  input  logic [AdrW-1:0]                  push_adr,
  input  logic [31:0]                      push_data,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH)-1:0]         rd_ptr,
  output logic [$clog2(DEPTH):0]           count,
  output logic [AdrW-1:0]                  head_adr,
  output logic [31:0]                      head_data,
  output logic [DEPTH-1:0][AdrW-1:0]       entry_adr,
  output logic [DEPTH-1:0][31:0]           entry_data
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]             count_q, count_d;
  logic [DEPTH-1:0][AdrW-1:0]  adr_q;
  logic [DEPTH-1:0][31:0]      data_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: entries are only visible below count.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[wr_ptr_q]  <= push_adr;
      data_q[wr_ptr_q] <= push_data;
    end
  end

  assign full       = (count_q == CntW'(DEPTH));
  assign empty      = (count_q == '0);
  assign rd_ptr     = rd_ptr_q;
  assign count      = count_q;
  assign head_adr   = adr_q[rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];
  assign entry_adr  = adr_q;
  assign entry_data = data_q;

endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer between core and memory: FIFO drain, load forwarding, read priority.
module store_buffer
  import arm_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  sb_state_e                   state_q, state_d;
  logic [31:0]                 rdata_q;
  logic                        push, pop, full, empty;
  logic [PtrW-1:0]             rd_ptr;
  logic [CntW-1:0]             count;
  logic [AdrW-1:0]             head_adr;
  logic [31:0]                 head_data;
  logic [DEPTH-1:0][AdrW-1:0]  entry_adr;
  logic [DEPTH-1:0][31:0]      entry_data;
  logic                        load, hit, miss;
  logic [31:0]                 hit_data;
  logic [PtrW-1:0]             idx;
  logic                        unused_adr_lsb;

  assign unused_adr_lsb = ^cpu_adr[1:0];

  sbuf_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_adr  (cpu_adr[31:2]),
    .push_data (cpu_wd),
    .full      (full),
    .empty     (empty),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .head_adr  (head_adr),
    .head_data (head_data),
    .entry_adr (entry_adr),
    .entry_data(entry_data)
  );

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PtrW'(i);
      if ((CntW'(i) < count) && (entry_adr[idx] == cpu_adr[31:2])) begin
        hit      = 1'b1;
        hit_data = entry_data[idx];
      end
    end
  end

  // A simultaneous store wins over a load.
  assign load = cpu_re & ~cpu_we;
  assign miss = load & ~hit;

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wd    = '0;
    cpu_rd    = '0;
    cpu_stall = 1'b0;
    pop       = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (miss)        state_d = StRead;
        else if (!empty) state_d = StWrite;
      end
      StWrite: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        mem_adr = {head_adr, 2'b00};
        mem_wd  = head_data;
        if (mem_ack) begin
          pop     = 1'b1;
          state_d = StIdle;
        end
      end
      StRead: begin
        mem_req = 1'b1;
        mem_adr = {cpu_adr[31:2], 2'b00};
        if (mem_ack) state_d = StRdone;
      end
      StRdone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_q == StRdone) cpu_rd = rdata_q;
    else if (load && hit)   cpu_rd = hit_data;

    // A draining ack frees the slot a full-buffer store needs in the same cycle.
    cpu_stall = (cpu_we && full && !pop) || (miss && (state_q != StRdone));
    push      = cpu_we && !cpu_stall;

    if (reset) begin
      cpu_stall = 1'b0;
      cpu_rd    = '0;
      push      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == StRead) && mem_ack) rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH = 4).
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we, cpu_re;
  logic [31:0] cpu_adr, cpu_wd, cpu_rd;
  logic        cpu_stall;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_adr, mem_wd, mem_rdata;

  int checks = 0;
  int errors = 0;

  store_buffer #(
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_we   (cpu_we),
    .cpu_re   (cpu_re),
    .cpu_adr  (cpu_adr),
    .cpu_wd   (cpu_wd),
    .cpu_rd   (cpu_rd),
    .cpu_stall(cpu_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_adr  (mem_adr),
    .mem_wd   (mem_wd),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller on a falling edge with mem_req high, or ok=0 after the bound.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; cpu_adr = '0; cpu_wd = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_req, mem_we, mem_adr, mem_wd, cpu_stall, cpu_rd} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0",
               {mem_req, mem_we, mem_adr, mem_wd, cpu_stall, cpu_rd});
    end
    @(negedge clk);
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_store();
    cpu_we = 1'b1; cpu_adr = 32'h64; cpu_wd = 32'h7;
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++; $display("FAIL single_accept stall got %b expected 0", cpu_stall);
    end
    next_cycle();
    cpu_we = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL single_idle_req got %b expected 0", mem_req);
    end
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      mem_ack = (i == 2);
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_adr, mem_wd} !== {1'b1, 1'b1, 32'h64, 32'h7}) begin
        errors++;
        $display("FAIL single_write_%0d got %h expected %h", i,
                 {mem_req, mem_we, mem_adr, mem_wd}, {1'b1, 1'b1, 32'h64, 32'h7});
      end
      next_cycle();
    end
    mem_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0) begin
        errors++; $display("FAIL single_drained req got %b expected 0", mem_req);
      end
      next_cycle();
    end
  endtask

  task automatic test_full_stall();
    bit ok;
    for (int i = 0; i < 4; i++) begin
      cpu_we = 1'b1; cpu_adr = 32'h60 + 32'(4 * i); cpu_wd = 32'h10 + 32'(i);
      @(negedge clk);
      checks++;
      if (cpu_stall !== 1'b0) begin
        errors++; $display("FAIL fill_%0d stall got %b expected 0", i, cpu_stall);
      end
      next_cycle();
    end
    cpu_adr = 32'h70; cpu_wd = 32'h14;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (cpu_stall !== 1'b1) begin
        errors++; $display("FAIL full_stall_%0d got %b expected 1", i, cpu_stall);
      end
      next_cycle();
    end
    mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpu_stall, mem_adr, mem_wd} !== {1'b0, 32'h60, 32'h10}) begin
      errors++;
      $display("FAIL full_ack_accept got %h expected %h",
               {cpu_stall, mem_adr, mem_wd}, {1'b0, 32'h60, 32'h10});
    end
    next_cycle();
    cpu_we = 1'b0; mem_ack = 1'b0;
    for (int i = 1; i < 5; i++) begin
      wait_req(ok);
      checks++;
      if (!ok || {mem_we, mem_adr, mem_wd} !== {1'b1, 32'h60 + 32'(4 * i), 32'h10 + 32'(i)}) begin
        errors++;
        $display("FAIL drain_%0d got ok=%0d %h expected %h", i, ok, {mem_we, mem_adr, mem_wd},
                 {1'b1, 32'h60 + 32'(4 * i), 32'h10 + 32'(i)});
      end
      mem_ack = ok;
      next_cycle();
      mem_ack = 1'b0;
    end
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL full_drained req got %b expected 0", mem_req);
    end
    next_cycle();
  endtask

  task automatic test_forward();
    bit ok;
    cpu_we = 1'b1; cpu_adr = 32'h60; cpu_wd = 32'h1;
    next_cycle();
    cpu_wd = 32'h2;
    next_cycle();
    cpu_we = 1'b0; cpu_re = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpu_rd, cpu_stall, (mem_req & ~mem_we)} !== {32'h2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL forward_hit got %h expected %h",
               {cpu_rd, cpu_stall, (mem_req & ~mem_we)}, {32'h2, 1'b0, 1'b0});
    end
    next_cycle();
    cpu_re = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_rd !== 32'h0) begin
      errors++; $display("FAIL idle_rd got %h expected 0", cpu_rd);
    end
    next_cycle();
    for (int i = 1; i < 3; i++) begin
      wait_req(ok);
      checks++;
      if (!ok || {mem_adr, mem_wd} !== {32'h60, 32'(i)}) begin
        errors++;
        $display("FAIL forward_drain_%0d got ok=%0d %h expected %h", i, ok,
                 {mem_adr, mem_wd}, {32'h60, 32'(i)});
      end
      mem_ack = ok;
      next_cycle();
      mem_ack = 1'b0;
    end
    repeat (3) next_cycle();
  endtask

  task automatic test_load_miss();
    bit ok;
    cpu_we = 1'b1; cpu_adr = 32'h40; cpu_wd = 32'hA;
    next_cycle();
    cpu_adr = 32'h44; cpu_wd = 32'hB;
    next_cycle();
    cpu_we = 1'b0; cpu_re = 1'b1; cpu_adr = 32'h80;
    @(negedge clk);
    checks++;
    if ({cpu_stall, mem_req, mem_we, mem_adr} !== {1'b1, 1'b1, 1'b1, 32'h40}) begin
      errors++;
      $display("FAIL miss_during_write got %h expected %h",
               {cpu_stall, mem_req, mem_we, mem_adr}, {1'b1, 1'b1, 1'b1, 32'h40});
    end
    next_cycle();
    mem_ack = 1'b1;
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_stall, mem_req} !== 2'b10) begin
      errors++; $display("FAIL miss_idle got %b expected 10", {cpu_stall, mem_req});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({cpu_stall, mem_req, mem_we, mem_adr} !== {1'b1, 1'b1, 1'b0, 32'h80}) begin
      errors++;
      $display("FAIL read_issue got %h expected %h",
               {cpu_stall, mem_req, mem_we, mem_adr}, {1'b1, 1'b1, 1'b0, 32'h80});
    end
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD;
    next_cycle();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if ({cpu_rd, cpu_stall, mem_req} !== {32'hDEAD, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rdone got %h expected %h", {cpu_rd, cpu_stall, mem_req},
               {32'hDEAD, 1'b0, 1'b0});
    end
    cpu_re = 1'b0;
    next_cycle();
    wait_req(ok);
    checks++;
    if (!ok || {mem_we, mem_adr, mem_wd} !== {1'b1, 32'h44, 32'hB}) begin
      errors++;
      $display("FAIL miss_remaining got ok=%0d %h expected %h", ok,
               {mem_we, mem_adr, mem_wd}, {1'b1, 32'h44, 32'hB});
    end
    mem_ack = ok;
    next_cycle();
    mem_ack = 1'b0;
    repeat (3) next_cycle();
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    cpu_we = 1'b1; cpu_adr = 32'hC0; cpu_wd = 32'h3;
    next_cycle();
    cpu_we = 1'b0; cpu_re = 1'b1; cpu_adr = 32'h90;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_adr} !== {1'b1, 1'b0, 32'h90}) begin
      errors++;
      $display("FAIL read_before_reset got %h expected %h", {mem_req, mem_we, mem_adr},
               {1'b1, 1'b0, 32'h90});
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_adr, mem_wd, cpu_stall, cpu_rd} !== '0) begin
      errors++;
      $display("FAIL async_reset got %h expected 0",
               {mem_req, mem_we, mem_adr, mem_wd, cpu_stall, cpu_rd});
    end
    cpu_re = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    next_cycle();
    cpu_we = 1'b1; cpu_adr = 32'hB0; cpu_wd = 32'h9; mem_ack = 1'b1;
    next_cycle();
    cpu_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, cpu_stall} !== 2'b00) begin
      errors++; $display("FAIL stray_ack got %b expected 00", {mem_req, cpu_stall});
    end
    next_cycle();
    mem_ack = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok || {mem_adr, mem_wd} !== {32'hB0, 32'h9}) begin
      errors++;
      $display("FAIL post_reset_drain got ok=%0d %h expected %h", ok, {mem_adr, mem_wd},
               {32'hB0, 32'h9});
    end
    mem_ack = ok;
    next_cycle();
    mem_ack = 1'b0;
    repeat (4) next_cycle();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL discarded_store req got %b expected 0", mem_req);
    end
    next_cycle();
  endtask

  task automatic test_wrap();
    localparam int N = 2 * DEPTH + 1;
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    int idx = 0;
    for (int cyc = 0; cyc < 300 && got_a.size() < N; cyc++) begin
      cpu_we  = (idx < N);
      cpu_adr = 32'h100 + 32'(4 * idx);
      cpu_wd  = 32'h1000 + 32'(idx);
      @(negedge clk);
      mem_ack = mem_req;
      if (mem_req) begin
        got_a.push_back(mem_adr);
        got_d.push_back(mem_wd);
      end
      #1;
      if (cpu_we && !cpu_stall) idx++;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
    end
    cpu_we = 1'b0;
    checks++;
    if (got_a.size() != N) begin
      errors++; $display("FAIL wrap_count got %0d expected %0d", got_a.size(), N);
    end
    for (int i = 0; i < got_a.size(); i++) begin
      checks++;
      if ({got_a[i], got_d[i]} !== {32'h100 + 32'(4 * i), 32'h1000 + 32'(i)}) begin
        errors++;
        $display("FAIL wrap_order_%0d got %h expected %h", i, {got_a[i], got_d[i]},
                 {32'h100 + 32'(4 * i), 32'h1000 + 32'(i)});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_store();
    test_full_stall();
    test_forward();
    test_load_miss();
    test_reset_mid_read();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered store entries (power of two, >=2).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cpu_we  in  1  core store request (core MemWrite).
REQ-005 cpu_re  in  1  core load request.
REQ-006 cpu_adr  in  32  core data address (DataAdr); word-aligned, bits [1:0] ignored.
REQ-007 cpu_wd  in  32  core store data (WriteData).
REQ-008 cpu_rd  out  32  load data to core (ReadData).
REQ-009 cpu_stall  out  1  core must hold PC and all request inputs stable while high.
REQ-010 mem_req  out  1  memory transaction request.
REQ-011 mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
REQ-012 mem_adr  out  32  memory word address, with bits [1:0] = 0.
REQ-013 mem_wd  out  32  memory write data.
REQ-014 mem_ack  in  1  one-cycle completion pulse from memory.
REQ-015 mem_rdata  in  32  read data; valid only in the mem_ack cycle of a read.

Function
REQ-016 A store is accepted when cpu_we=1 and cpu_stall=0, and is appended at the tail in that cycle's rising edge; stores to the same address are never coalesced.
REQ-017 cpu_stall is asserted for a store when count==DEPTH; exception: if a write ack drains the head in that same cycle, the store is accepted and cpu_stall=0.
REQ-018 Drain order is strict FIFO; while count>0 and the FSM is idle, the head is presented as mem_req=1, mem_we=1, head address and data, held stable until mem_ack.
REQ-019 On a write mem_ack, the head is popped at that edge; the next request may assert in the following cycle.
REQ-020 Load hit means cpu_re=1 and some entry matches cpu_adr[31:2]; cpu_rd is driven combinationally with the youngest matching entry's data, and cpu_stall=0.
REQ-021 Load miss means cpu_re=1 with no match; cpu_stall=1 until the load completes.
REQ-022 FSM states: IDLE, WRITE, READ, RDONE.
REQ-023 IDLE goes to READ on a load miss, because a read has priority over pending stores; otherwise IDLE goes to WRITE when count>0.
REQ-024 WRITE goes to IDLE on mem_ack; a miss arriving during WRITE waits for that ack.
REQ-025 READ drives mem_req=1, mem_we=0, mem_adr={cpu_adr[31:2],2'b00}; on mem_ack, mem_rdata is captured and the FSM goes to RDONE.
REQ-026 RDONE drives cpu_rd = captured data and cpu_stall=0 for exactly one cycle, then returns to IDLE.
REQ-027 Minimum load-miss latency from an idle empty buffer: request cycle + 1 + memory wait, then data in RDONE.
REQ-028 Stores accepted during a read stall are impossible; the core is stalled, and cpu_we with cpu_re both set is illegal (cpu_we wins, cpu_re ignored).
REQ-029 When neither a load hit nor RDONE applies, cpu_rd = 0.
REQ-030 Count width is clog2(DEPTH)+1; read and write pointers wrap modulo DEPTH.

Reset
REQ-031 On reset: count=0, pointers=0, state=IDLE, mem_req=0, mem_we=0, mem_adr=0, mem_wd=0, cpu_stall=0, cpu_rd=0.
REQ-032 Reset during WRITE or READ abandons the transaction immediately; buffered stores are discarded, and a late mem_ack after reset is ignored.

Structure
REQ-033 Shared package arm_mem_pkg holds the DEPTH default, the state enum (IDLE/WRITE/READ/RDONE) and the address-compare width constant.
REQ-034 Storage and pointers live in one sub-module, sbuf_fifo (push, pop, full, empty, per-entry address/data visible for the associative match); the FSM and forwarding logic stay in store_buffer.

Verification
REQ-035 Single store to 0x64 with data 7, ack 2 cycles later -> mem_req high for 3 cycles with mem_adr=0x64, mem_wd=7, mem_we=1; count returns to 0.
REQ-036 Five back-to-back stores to 0x60..0x70 with ack withheld -> stall on the 5th; release ack -> 5th accepted in the ack cycle, drain order 0x60..0x70.
REQ-037 Stores 0x60=1 then 0x60=2 with ack withheld, then load 0x60 -> cpu_rd=2, cpu_stall=0 that cycle, no mem read.
REQ-038 Load 0x80 miss during pending write with mem_rdata=0xDEAD -> write completes first, read issued next, RDONE gives cpu_rd=0xDEAD, then remaining stores drain.
REQ-039 Reset asserted mid-READ -> all outputs 0 asynchronously; a stray mem_ack after release causes no pop and no state change.
REQ-040 Pointer wrap -> 2*DEPTH+1 stores with immediate acks; drained addresses and data match issue order exactly.
